// File: rtl/score_hex_display.sv
// Display-side reader for a two-digit BCD score counter: samples the digits and
// win flag, drives two active-low 7-segment digits, flashes on change, blinks on win.
module score_hex_display #(
    parameter int FLASH_CYCLES = 4,
    parameter int BLINK_HALF   = 3,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic [3:0] countL,
    input  logic [3:0] countH,
    input  logic       tc,
    output logic [6:0] hexL,
    output logic [6:0] hexH,
    output logic       scoreChanged,
    output logic       win,
    output logic       bcdErr
);

    localparam int MAX_COUNT = (FLASH_CYCLES > BLINK_HALF) ? FLASH_CYCLES : BLINK_HALF;
    localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        FLASH = 2'd1,
        WIN   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          phase, phase_n;

    logic [3:0] samp_l, samp_h;
    logic       samp_tc;
    logic [3:0] disp_l, disp_h;
    logic       disp_tc;
    logic       changed;
    logic       changed_q;
    logic       err_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    // Input stage: one register between the counter and the comparison.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            samp_l  <= '0;
            samp_h  <= '0;
            samp_tc <= 1'b0;
        end else begin
            samp_l  <= countL;
            samp_h  <= countH;
            samp_tc <= tc;
        end
    end

    assign changed = (samp_l != disp_l) || (samp_h != disp_h);

    // Display stage: latch the sampled value and flag a change for one clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            disp_l    <= '0;
            disp_h    <= '0;
            disp_tc   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            disp_l    <= samp_l;
            disp_h    <= samp_h;
            disp_tc   <= samp_tc;
            changed_q <= changed;
            err_q     <= err_q || (samp_l > 4'd9) || (samp_h > 4'd9);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= SHOW;
            cnt   <= '0;
            phase <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phase <= phase_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        case (state)
            SHOW: begin
                if (samp_tc) begin
                    state_n = WIN;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else if (changed) begin
                    state_n = FLASH;
                    cnt_n   = '0;
                end
            end
            FLASH: begin
                if (samp_tc) begin
                    state_n = WIN;
                    cnt_n   = '0;
                    phase_n = 1'b1;
                end else if (changed) begin
                    cnt_n = '0;
                end else if (cnt == FLASH_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WIN: begin
                // Score changes are absorbed here: the blink cadence never restarts.
                if (cnt == BLINK_LAST) begin
                    cnt_n   = '0;
                    phase_n = ~phase;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = SHOW;
                cnt_n   = '0;
                phase_n = 1'b1;
            end
        endcase
    end

    logic blank_all;
    logic blank_tens;

    assign blank_all  = !enable || (state == FLASH) || ((state == WIN) && !phase);
    assign blank_tens = BLANK_LZ && (disp_h == 4'd0);

    assign hexL         = blank_all ? SEG_BLANK : seg7(disp_l);
    assign hexH         = (blank_all || blank_tens) ? SEG_BLANK : seg7(disp_h);
    assign scoreChanged = changed_q;
    assign win          = (state == WIN);
    assign bcdErr       = err_q;

    // disp_tc mirrors the win flag alongside the digits; the FSM acts on samp_tc.
    logic unused_ok;
    assign unused_ok = disp_tc;

endmodule

// File: tb/tb_score_hex_display.sv
// Scoreboard bench for score_hex_display: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_score_hex_display;

    logic       clk;
    logic       resetN;
    logic       enable;
    logic [3:0] countL;
    logic [3:0] countH;
    logic       tc;
    logic [6:0] hexL;
    logic [6:0] hexH;
    logic       scoreChanged;
    logic       win;
    logic       bcdErr;

    typedef struct packed {
        logic [6:0] hl;
        logic [6:0] hh;
        logic       sc;
        logic       w;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cycle_no;

    score_hex_display #(
        .FLASH_CYCLES(4),
        .BLINK_HALF  (3),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .countL      (countL),
        .countH      (countH),
        .tc          (tc),
        .hexL        (hexL),
        .hexH        (hexH),
        .scoreChanged(scoreChanged),
        .win         (win),
        .bcdErr      (bcdErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after the rising edge for n cycles, queueing what the
    // monitor should see in each of those cycles.
    task automatic cyc(input int n, input logic rn, input logic en,
                       input logic [3:0] l, input logic [3:0] h, input logic t,
                       input logic [6:0] ehl, input logic [6:0] ehh,
                       input logic esc, input logic ew, input logic ee);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            resetN = rn;
            enable = en;
            countL = l;
            countH = h;
            tc     = t;
            e.hl = ehl;
            e.hh = ehh;
            e.sc = esc;
            e.w  = ew;
            e.e  = ee;
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        cycle_no = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.hl = hexL;
                a.hh = hexH;
                a.sc = scoreChanged;
                a.w  = win;
                a.e  = bcdErr;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got hexL=%h hexH=%h sc=%b win=%b err=%b, want hexL=%h hexH=%h sc=%b win=%b err=%b",
                             cycle_no, a.hl, a.hh, a.sc, a.w, a.e, e.hl, e.hh, e.sc, e.w, e.e);
                end
                cycle_no++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        resetN = 1'b0;
        enable = 1'b1;
        countL = 4'd0;
        countH = 4'd0;
        tc     = 1'b0;

        // Reset and idle at score 00: tens blanked as a leading zero.
        cyc(3,  0, 1, 4'd0, 4'd0, 0, 7'h40, 7'h7F, 0, 0, 0);
        cyc(20, 1, 1, 4'd0, 4'd0, 0, 7'h40, 7'h7F, 0, 0, 0);

        // Units 0->3: pulse at t+2, four blank clocks, then "3".
        cyc(2, 1, 1, 4'd3, 4'd0, 0, 7'h40, 7'h7F, 0, 0, 0);
        cyc(1, 1, 1, 4'd3, 4'd0, 0, 7'h7F, 7'h7F, 1, 0, 0);
        cyc(3, 1, 1, 4'd3, 4'd0, 0, 7'h7F, 7'h7F, 0, 0, 0);
        cyc(4, 1, 1, 4'd3, 4'd0, 0, 7'h30, 7'h7F, 0, 0, 0);

        // Score 12, then 13 two clocks later: flash restarts, six blank clocks.
        cyc(2, 1, 1, 4'd2, 4'd1, 0, 7'h30, 7'h7F, 0, 0, 0);
        cyc(1, 1, 1, 4'd3, 4'd1, 0, 7'h7F, 7'h7F, 1, 0, 0);
        cyc(1, 1, 1, 4'd3, 4'd1, 0, 7'h7F, 7'h7F, 0, 0, 0);
        cyc(1, 1, 1, 4'd3, 4'd1, 0, 7'h7F, 7'h7F, 1, 0, 0);
        cyc(3, 1, 1, 4'd3, 4'd1, 0, 7'h7F, 7'h7F, 0, 0, 0);
        cyc(4, 1, 1, 4'd3, 4'd1, 0, 7'h30, 7'h79, 0, 0, 0);

        // Illegal units digit: sticky error, "E" after the flash; back to 5.
        cyc(2, 1, 1, 4'hC, 4'd1, 0, 7'h30, 7'h79, 0, 0, 0);
        cyc(1, 1, 1, 4'hC, 4'd1, 0, 7'h7F, 7'h7F, 1, 0, 1);
        cyc(3, 1, 1, 4'hC, 4'd1, 0, 7'h7F, 7'h7F, 0, 0, 1);
        cyc(3, 1, 1, 4'hC, 4'd1, 0, 7'h06, 7'h79, 0, 0, 1);
        cyc(2, 1, 1, 4'd5, 4'd1, 0, 7'h06, 7'h79, 0, 0, 1);
        cyc(1, 1, 1, 4'd5, 4'd1, 0, 7'h7F, 7'h7F, 1, 0, 1);
        cyc(3, 1, 1, 4'd5, 4'd1, 0, 7'h7F, 7'h7F, 0, 0, 1);
        cyc(3, 1, 1, 4'd5, 4'd1, 0, 7'h12, 7'h79, 0, 0, 1);

        // Win at 99: WIN beats FLASH, blink 3 on / 3 off.
        cyc(2, 1, 1, 4'd9, 4'd9, 1, 7'h12, 7'h79, 0, 0, 1);
        cyc(1, 1, 1, 4'd9, 4'd9, 1, 7'h10, 7'h10, 1, 1, 1);
        cyc(2, 1, 1, 4'd9, 4'd9, 1, 7'h10, 7'h10, 0, 1, 1);
        cyc(3, 1, 1, 4'd9, 4'd9, 1, 7'h7F, 7'h7F, 0, 1, 1);
        cyc(1, 1, 1, 4'd9, 4'd9, 1, 7'h10, 7'h10, 0, 1, 1);

        // Score 98 during WIN: pulse lands in the off phase, blink cadence unchanged.
        cyc(2, 1, 1, 4'd8, 4'd9, 1, 7'h10, 7'h10, 0, 1, 1);
        cyc(1, 1, 1, 4'd8, 4'd9, 1, 7'h7F, 7'h7F, 1, 1, 1);
        cyc(2, 1, 1, 4'd8, 4'd9, 1, 7'h7F, 7'h7F, 0, 1, 1);
        cyc(3, 1, 1, 4'd8, 4'd9, 1, 7'h00, 7'h10, 0, 1, 1);
        cyc(3, 1, 1, 4'd8, 4'd9, 1, 7'h7F, 7'h7F, 0, 1, 1);

        // Display disabled across a full blink period, then re-enabled in the on phase.
        cyc(6, 1, 0, 4'd8, 4'd9, 1, 7'h7F, 7'h7F, 0, 1, 1);
        cyc(2, 1, 1, 4'd8, 4'd9, 1, 7'h00, 7'h10, 0, 1, 1);

        // Asynchronous reset mid-blink: reset values appear before the next edge.
        cyc(2, 0, 1, 4'd8, 4'd9, 1, 7'h40, 7'h7F, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_hex_display.md
Name: score_hex_display

Overview:
- Display-side reader for the two-digit BCD score counter.
- Samples the counter's units digit, tens digit and terminal-count (win) flag, and drives two active-low 7-segment digits.
- Flashes the display briefly on every score change, and blinks it indefinitely once the win flag is seen.
- Sits between the scoreboard counter and the board HEX outputs; flags illegal BCD input.

Parameters:
- FLASH_CYCLES, 4, number of clocks both digits stay blanked after a score change (set to 12_500_000 at top level).
- BLINK_HALF, 3, clocks per on/off half-period of the win blink (set to 25_000_000 at top level).
- BLANK_LZ, 1, 1 = blank the tens digit when it is 0.

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- enable  input  1  1 = display on; 0 = all segments off, internal logic keeps running.
- countL  input  4  BCD units digit from the score counter.
- countH  input  4  BCD tens digit from the score counter.
- tc  input  1  sticky win/terminal-count flag from the score counter.
- hexL  output  7  units segments, active-low, bit0=a .. bit6=g.
- hexH  output  7  tens segments, same encoding.
- scoreChanged  output  1  one-clock pulse when the displayed score value changes.
- win  output  1  high while in WIN state.
- bcdErr  output  1  sticky; set when either digit input is greater than 9.

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous and active-low.
- Reset values:
  - sampL/sampH/sampTc = 0 and dispL/dispH/dispTc = 0.
  - state = SHOW; blink/flash counter = 0; blink phase = on.
  - hexL = 7'h40 ("0"); hexH = 7'h7F when BLANK_LZ=1, else 7'h40.
  - scoreChanged = 0, win = 0, bcdErr = 0.
- Pipeline:
  - Edge 1: inputs are registered into samp*.
  - Edge 2: the FSM compares samp* against disp*, then disp* <= samp*.
  - hexL/hexH are combinational from disp*, state, phase and enable only.
  - Input change to first visible response = 2 clocks.
- Change detect: (sampL,sampH) != (dispL,dispH) at edge 2 -> scoreChanged = 1 for exactly one clock. This happens in every state.
- States:
  - SHOW: both digits displayed.
    - Score change -> FLASH, counter = 0.
    - sampTc = 1 -> WIN. WIN takes priority over FLASH.
  - FLASH: both digits blanked (7'h7F).
    - The counter increments each clock; at FLASH_CYCLES-1 -> SHOW. Blank duration is exactly FLASH_CYCLES clocks.
    - A new change during FLASH restarts the counter at 0.
    - sampTc = 1 -> WIN immediately.
  - WIN: win = 1.
    - The counter counts 0..BLINK_HALF-1, then wraps to 0 and toggles phase. Phase on = digits shown, off = 7'h7F.
    - The phase on entry is on.
    - Score changes update disp* and pulse scoreChanged, but do not leave WIN and do not restart the blink.
    - WIN exits only on reset.
- Segment codes (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - invalid (>9) = 06 ("E"); blank = 7F
- Leading zero: with BLANK_LZ=1 and dispH = 0, hexH = 7F in every state. An invalid tens digit is never blanked; it shows "E".
- bcdErr: set the clock after sampL>9 or sampH>9; held until reset. A digit >9 counts as a change like any other value.
- enable = 0 forces hexL = hexH = 7F. FSM, counters, scoreChanged, win and bcdErr behave unchanged.
- Reset mid-FLASH or mid-WIN returns to the reset values immediately (asynchronous).
- Width rules: the counter must be wide enough for max(FLASH_CYCLES, BLINK_HALF) - 1. FLASH_CYCLES >= 1 and BLINK_HALF >= 1.

Test Plan:
- After reset, with countL=0, countH=0, tc=0, enable=1 -> hexL=40, hexH=7F, scoreChanged=0 for 20 clocks.
- Step countL 0->3 at cycle t:
  - scoreChanged=1 only during cycle t+2.
  - hexL=hexH=7F for cycles t+2..t+5 (4 clocks).
  - Then hexL=30 and hexH=7F from cycle t+6.
- countH=1, countL=2, then countL->3 two clocks after the flash starts -> the flash restarts, giving 6 blank clocks in total; final hexH=79, hexL=30.
- tc 0->1 with score 99 -> win=1 at t+2. Digits then alternate:
  - 3 clocks showing hexH=hexL=10;
  - 3 clocks at 7F;
  - repeating.
  - A further countL change pulses scoreChanged and win stays 1.
- countL=4'hC -> bcdErr=1 and hexL=06 after the flash. Return countL to 5 -> bcdErr stays 1 and hexL=12.
- enable=0 during WIN -> hexL=hexH=7F constantly. Assert resetN=0 mid-blink -> all outputs return to their reset values asynchronously.
